phase_sampler: RTL and testbench

//  Samples the free-running ring-oscillator taps (sout/dout of shorted RO cells) into the clk domain.

---
 rtl/phase_sampler_if.sv | 25 ++
 rtl/phase_sampler.sv | 115 +++++++++++
 tb/tb_phase_sampler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/phase_sampler_if.sv
// Bus for phase_sampler: raw RO taps and measurement control in,
// per-oscillator phase decisions and agreement counts out.
interface phase_sampler_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic [N-1:0]       osc_in;
  logic               start;
  logic [CNT_W-1:0]   window_len;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       spin;
  logic [N*CNT_W-1:0] agree_cnt;

  modport master (
    output osc_in, start, window_len, out_ready,
    input  busy, out_valid, spin, agree_cnt
  );

  modport slave (
    input  osc_in, start, window_len, out_ready,
    output busy, out_valid, spin, agree_cnt
  );
endinterface

// File: rtl/phase_sampler.sv
// Samples asynchronous ring-oscillator taps, counts per-tap agreement with tap 0
// over a programmable window and thresholds each count into a spin bit.
module phase_sampler #(
  parameter int N           = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  phase_sampler_if.slave bus
);

  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  state_t                       state_reg;
  logic [SYNC_STAGES-1:0][N-1:0] sync_reg;
  logic [N-1:0]                 s;
  logic [CNT_W-1:0]             len_reg;
  logic [CNT_W-1:0]             cyc_reg;
  logic [SET_W-1:0]             settle_reg;
  logic [N-1:0][CNT_W-1:0]      cnt_reg;
  logic [N-1:0][CNT_W-1:0]      cnt_next;
  logic [N-1:0][CNT_W-1:0]      agree_reg;
  logic [N-1:0]                 match;
  logic [N-1:0]                 spin_next;
  logic [N-1:0]                 spin_reg;
  logic                         busy_reg;
  logic                         out_valid_reg;

  // Synchronizer runs in every state so SETTLE only has to flush stale history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.osc_in};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_osc
      assign match[gi]     = (s[gi] == s[0]);
      assign cnt_next[gi]  = cnt_reg[gi] + {{(CNT_W-1){1'b0}}, match[gi]};
      // Doubling in CNT_W+1 bits keeps the strict-majority test overflow free.
      assign spin_next[gi] = ({cnt_next[gi], 1'b0} > {1'b0, len_reg});
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      spin_reg      <= '0;
      agree_reg     <= '0;
      len_reg       <= '0;
      cyc_reg       <= '0;
      settle_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            len_reg    <= (bus.window_len == '0) ? CNT_W'(1) : bus.window_len;
            cnt_reg    <= '0;
            cyc_reg    <= '0;
            settle_reg <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= SETTLE;
          end
        end
        SETTLE: begin
          settle_reg <= settle_reg + SET_W'(1);
          if (settle_reg == SET_W'(SYNC_STAGES - 1)) begin
            state_reg <= MEASURE;
          end
        end
        MEASURE: begin
          cnt_reg <= cnt_next;
          cyc_reg <= cyc_reg + CNT_W'(1);
          // Result is captured from the final cycle's count so out_valid rises on DONE entry.
          if (cyc_reg == len_reg - CNT_W'(1)) begin
            agree_reg     <= cnt_next;
            spin_reg      <= spin_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.spin      = spin_reg;
  assign bus.agree_cnt = agree_reg;

endmodule

// File: tb/tb_phase_sampler.sv
// Directed bench for phase_sampler: expected results are pushed to a scoreboard
// when a measurement is launched and popped when out_valid is observed.
module tb_phase_sampler;
  localparam int N     = 8;
  localparam int CNT_W = 16;
  localparam int SS    = 2;
  localparam int W     = N * CNT_W;

  typedef struct {
    logic [N-1:0]            spin;
    logic [N-1:0][CNT_W-1:0] cnt;
    int unsigned             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phase_sampler_if #(.N(N), .CNT_W(CNT_W)) bus ();

  phase_sampler #(.N(N), .CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  exp_t        sb_q[$];
  int unsigned edge_cnt = 0;

  // Asynchronous ~37 MHz square wave (half periods 13/14 against a 10-unit clock).
  logic         wave = 1'b0;
  bit           async_mode = 1'b1;
  logic [N-1:0] inv_mask = '0;
  logic [N-1:0] sync_val = '0;
  int unsigned  half_p [N] = '{default: 1};
  int unsigned  phase  [N] = '{default: 0};

  initial forever begin
    #13 wave = ~wave;
    #14 wave = ~wave;
  end

  always @(posedge clk) edge_cnt++;

  // Edge-synchronous patterns: value for edge k is applied at the preceding negedge.
  function automatic logic [N-1:0] osc_fn(int unsigned k);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (((k + phase[i]) / half_p[i]) % 2) == 1;
    return v;
  endfunction

  always @(negedge clk) sync_val = osc_fn(edge_cnt + 1);

  assign bus.osc_in = async_mode ? ({N{wave}} ^ inv_mask) : sync_val;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Start accepted at edge P; samples from edges P+1..P+len are the ones counted.
  task automatic launch(int unsigned len_in);
    exp_t         e;
    int unsigned  len_eff;
    int unsigned  p;
    int unsigned  c [N];
    logic [N-1:0] v;
    len_eff = (len_in == 0) ? 1 : len_in;
    p = edge_cnt + 1;
    for (int i = 0; i < N; i++) c[i] = 0;
    if (async_mode) begin
      for (int i = 0; i < N; i++) c[i] = inv_mask[i] ? 0 : len_eff;
    end else begin
      for (int unsigned k = p + 1; k <= p + len_eff; k++) begin
        v = osc_fn(k);
        for (int i = 0; i < N; i++) if (v[i] == v[0]) c[i]++;
      end
    end
    for (int i = 0; i < N; i++) begin
      e.cnt[i]  = CNT_W'(c[i]);
      e.spin[i] = (2 * c[i] > len_eff);
    end
    e.lat = SS + len_eff;
    sb_q.push_back(e);
    bus.window_len = CNT_W'(len_in);
    bus.start = 1'b1;
    step();
    chk("accept_busy", W'(bus.busy), W'(1));
    bus.start = 1'b0;
  endtask

  task automatic collect(string tag, int hold, bit start_on_accept);
    exp_t e;
    int   k;
    k = 0;
    e = sb_q.pop_front();
    while (bus.out_valid !== 1'b1 && k < int'(e.lat) + 20) begin
      step();
      k++;
    end
    chk({tag, "_valid"}, W'(bus.out_valid), W'(1));
    chk({tag, "_latency"}, W'(k), W'(e.lat));
    chk({tag, "_spin"}, W'(bus.spin), W'(e.spin));
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_cnt%0d", tag, i), W'(bus.agree_cnt[i*CNT_W +: CNT_W]), W'(e.cnt[i]));
    for (int h = 0; h < hold; h++) begin
      bus.start = (h % 5 == 2);
      step();
      chk({tag, "_hold_valid"}, W'(bus.out_valid), W'(1));
      chk({tag, "_hold_busy"}, W'(bus.busy), W'(1));
      chk({tag, "_hold_spin"}, W'(bus.spin), W'(e.spin));
      chk({tag, "_hold_cnt"}, bus.agree_cnt, e.cnt);
    end
    bus.start = start_on_accept;
    bus.out_ready = 1'b1;
    step();
    chk({tag, "_acc_valid"}, W'(bus.out_valid), W'(0));
    chk({tag, "_acc_busy"}, W'(bus.busy), W'(0));
    chk({tag, "_keep_spin"}, W'(bus.spin), W'(e.spin));
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    $display("window %s: len_lat=%0d spin=%02h", tag, e.lat, bus.spin);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    bus.window_len = '0;
    repeat (3) step();
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_valid", W'(bus.out_valid), W'(0));
    chk("rst_spin", W'(bus.spin), W'(0));
    chk("rst_cnt", bus.agree_cnt, W'(0));
    rst_n = 1'b1;
    repeat (2) step();

    // All taps on one asynchronous wave.
    async_mode = 1'b1;
    inv_mask = '0;
    launch(100);
    collect("in_phase", 0, 1'b0);

    // Upper four taps inverted.
    inv_mask = 8'hF0;
    launch(200);
    collect("anti_phase", 0, 1'b0);

    // Reset asserted mid-measurement while taps keep toggling.
    launch(200);
    repeat (50) step();
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(bus.busy), W'(0));
    chk("abort_valid", W'(bus.out_valid), W'(0));
    chk("abort_spin", W'(bus.spin), W'(0));
    chk("abort_cnt", bus.agree_cnt, W'(0));
    void'(sb_q.pop_front());
    repeat (2) step();
    rst_n = 1'b1;
    repeat (250) step();
    chk("abort_no_result", W'(bus.out_valid), W'(0));
    chk("abort_idle", W'(bus.busy), W'(0));

    // Tap 1 alternates against a constant reference: exactly half agree.
    async_mode = 1'b0;
    for (int i = 0; i < N; i++) begin
      half_p[i] = i + 1;
      phase[i] = i;
    end
    half_p[0] = 32'h4000_0000;
    phase[0] = 0;
    half_p[1] = 1;
    repeat (2) step();
    launch(100);
    chk("tie_model_cnt1", W'(sb_q[0].cnt[1]), W'(50));
    collect("tie", 0, 1'b0);

    launch(0);
    collect("zero_len", 0, 1'b0);

    // Backpressure with ignored starts, then a start on the accept cycle.
    for (int i = 0; i < N; i++) begin
      half_p[i] = $urandom_range(1, 6);
      phase[i] = $urandom_range(0, 11);
    end
    repeat (2) step();
    launch(60);
    collect("backpressure", 20, 1'b1);
    launch(40);
    collect("restart", 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        half_p[i] = $urandom_range(1, 7);
        phase[i] = $urandom_range(0, 15);
      end
      repeat (2) step();
      launch($urandom_range(20, 300));
      collect($sformatf("random%0d", r), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
